// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter
//   Shares one router injection port between NUM_REQ compute nodes. Each
//   requester pushes flits into its own small FIFO. A round-robin arbiter
//   drains the FIFOs into a registered valid/ready output stage. Flits pass
//   through unmodified.
//
// Ports
//   clk           single clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   req_flit      requester i flit on bits [i*FLIT_W +: FLIT_W]
//   req_send      push strobe per requester; every high cycle is one push
//   req_full      FIFO i holds FIFO_DEPTH flits (status only)
//   req_overflow  sticky: a push to FIFO i was dropped
//   out_flit      flit presented to the router
//   out_valid     out_flit holds a flit
//   out_ready     router accepts out_flit this cycle
//   out_src       requester index of the current out_flit

module noc_inject_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FLIT_W     = 71,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ*FLIT_W-1:0]  req_flit,
    input  logic [NUM_REQ-1:0]         req_send,
    output logic [NUM_REQ-1:0]         req_full,
    output logic [NUM_REQ-1:0]         req_overflow,
    output logic [FLIT_W-1:0]          out_flit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] out_src
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    logic [FLIT_W-1:0] mem    [NUM_REQ][FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr [NUM_REQ];
    logic [AW-1:0]     wr_ptr [NUM_REQ];
    logic [CW-1:0]     count  [NUM_REQ];

    logic [NUM_REQ-1:0] not_empty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   winner;
    logic               found;
    logic               load;

    // FIFO status comes from registered occupancy only, so a flit pushed on
    // an edge can be popped no earlier than the following edge.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            not_empty[i] = (count[i] != '0);
            req_full[i]  = (count[i] == CW'(FIFO_DEPTH));
        end
    end

    // Round-robin search: first non-empty FIFO starting at rr_ptr.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] cand;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = SRC_W'(idx);
            if (!found && not_empty[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign load = (!out_valid || out_ready) && found;

    // A push to a full FIFO is accepted only when the same FIFO pops on
    // that edge; occupancy is then unchanged.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i]  = load && (winner == SRC_W'(i));
            push[i] = req_send[i] && (!req_full[i] || pop[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            req_overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
                if (req_send[i] && !push[i]) req_overflow[i] <= 1'b1;
            end
        end
    end

    // NOTE: FIFO storage has no reset; pointers and counts are reset, so stale entries are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= req_flit[i*FLIT_W +: FLIT_W];
        end
    end

    // Output stage: loads when empty or being accepted; holds on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_flit  <= mem[winner][rd_ptr[winner]];
            out_src   <= winner;
            out_valid <= 1'b1;
            rr_ptr    <= (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + SRC_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter
//   Directed bench for noc_inject_arbiter (NUM_REQ=4, FLIT_W=71,
//   FIFO_DEPTH=4). Inputs change 1 time unit after each rising edge and
//   outputs are sampled at the same point.

module tb_noc_inject_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FLIT_W  = 71;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ*FLIT_W-1:0] req_flit;
    logic [NUM_REQ-1:0]        req_send;
    logic [NUM_REQ-1:0]        req_full;
    logic [NUM_REQ-1:0]        req_overflow;
    logic [FLIT_W-1:0]         out_flit;
    logic                      out_valid;
    logic                      out_ready;
    logic [1:0]                out_src;

    int n_cmp = 0;
    int n_err = 0;

    noc_inject_arbiter #(.NUM_REQ(4), .FLIT_W(71), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_flit     (req_flit),
        .req_send     (req_send),
        .req_full     (req_full),
        .req_overflow (req_overflow),
        .out_flit     (out_flit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_src      (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [70:0] mk(input logic [3:0] dest, input logic [63:0] pay);
        return {1'b1, 1'b0, dest, 1'b0, pay};
    endfunction

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [70:0] f);
        req_flit[idx*FLIT_W +: FLIT_W] = f;
        req_send[idx] = 1'b1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] src, input logic [70:0] f);
        check({tag, "_valid"}, 71'(out_valid), 71'd1);
        check({tag, "_src"},   71'(out_src),   71'(src));
        check({tag, "_flit"},  out_flit,       f);
    endtask

    logic [70:0] f_single;

    initial begin
        rst_n     = 1'b0;
        req_flit  = '0;
        req_send  = '0;
        out_ready = 1'b0;
        f_single  = 71'h7_C0000000000000005;

        // Reset state
        #3;
        check("rst_valid",    71'(out_valid),    71'd0);
        check("rst_flit",     out_flit,          71'd0);
        check("rst_src",      71'(out_src),      71'd0);
        check("rst_full",     71'(req_full),     71'd0);
        check("rst_overflow", 71'(req_overflow), 71'd0);
        tick();
        rst_n = 1'b1;

        // Single push on requester 2
        out_ready = 1'b1;
        send(2, f_single);
        tick();
        req_send = '0;
        check("single_not_yet", 71'(out_valid), 71'd0);
        tick();
        expect_out("single", 2'd2, f_single);
        tick();
        check("single_drop_valid", 71'(out_valid), 71'd0);
        check("single_hold_flit",  out_flit,       f_single);
        check("single_hold_src",   71'(out_src),   71'd2);

        // Round-robin from pointer 0
        tick();
        pulse_reset();
        for (int i = 0; i < 4; i++) send(i, mk(4'(i), 64'(10 + i)));
        tick();
        req_send = '0;
        check("rr_not_yet", 71'(out_valid), 71'd0);
        tick(); expect_out("rr0", 2'd0, mk(4'd0, 64'd10));
        tick(); expect_out("rr1", 2'd1, mk(4'd1, 64'd11));
        tick(); expect_out("rr2", 2'd2, mk(4'd2, 64'd12));
        tick(); expect_out("rr3", 2'd3, mk(4'd3, 64'd13));
        tick(); check("rr_idle", 71'(out_valid), 71'd0);

        // Backpressure: 6 cycles of out_ready=0 while requester 1 pushes 3 flits
        out_ready = 1'b0;
        send(1, mk(4'd5, 64'd20));
        tick();
        check("bp_not_yet", 71'(out_valid), 71'd0);
        send(1, mk(4'd5, 64'd21));
        tick();
        expect_out("bp_first", 2'd1, mk(4'd5, 64'd20));
        send(1, mk(4'd5, 64'd22));
        tick();
        req_send = '0;
        expect_out("bp_stall_c", 2'd1, mk(4'd5, 64'd20));
        tick(); expect_out("bp_stall_d", 2'd1, mk(4'd5, 64'd20));
        tick(); expect_out("bp_stall_e", 2'd1, mk(4'd5, 64'd20));
        tick(); expect_out("bp_stall_f", 2'd1, mk(4'd5, 64'd20));
        out_ready = 1'b1;
        tick(); expect_out("bp_drain1", 2'd1, mk(4'd5, 64'd21));
        tick(); expect_out("bp_drain2", 2'd1, mk(4'd5, 64'd22));
        tick(); check("bp_idle", 71'(out_valid), 71'd0);

        // Overflow on requester 0: 6 pushes with the port stalled
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send(0, mk(4'd1, 64'(30 + k)));
            tick();
            if (k == 4) begin
                check("ovf_full_at5",  71'(req_full[0]),     71'd1);
                check("ovf_clear_at5", 71'(req_overflow[0]), 71'd0);
            end
        end
        req_send = '0;
        check("ovf_set",      71'(req_overflow), 71'b0001);
        check("ovf_full",     71'(req_full),     71'b0001);
        expect_out("ovf_head", 2'd0, mk(4'd1, 64'd30));
        out_ready = 1'b1;
        tick();
        expect_out("ovf_d31", 2'd0, mk(4'd1, 64'd31));
        check("ovf_not_full", 71'(req_full[0]), 71'd0);
        tick(); expect_out("ovf_d32", 2'd0, mk(4'd1, 64'd32));
        tick(); expect_out("ovf_d33", 2'd0, mk(4'd1, 64'd33));
        tick(); expect_out("ovf_d34", 2'd0, mk(4'd1, 64'd34));
        tick();
        check("ovf_idle",   71'(out_valid),    71'd0);
        check("ovf_sticky", 71'(req_overflow), 71'b0001);

        // Full FIFO 3 with push and pop on the same edge
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(3, mk(4'd3, 64'(40 + k)));
            tick();
        end
        check("col_full_before", 71'(req_full[3]), 71'd1);
        expect_out("col_head", 2'd3, mk(4'd3, 64'd40));
        out_ready = 1'b1;
        send(3, mk(4'd3, 64'd45));
        tick();
        req_send = '0;
        check("col_no_ovf",     71'(req_overflow[3]), 71'd0);
        check("col_still_full", 71'(req_full[3]),     71'd1);
        expect_out("col_d41", 2'd3, mk(4'd3, 64'd41));
        tick(); expect_out("col_d42", 2'd3, mk(4'd3, 64'd42));
        tick(); expect_out("col_d43", 2'd3, mk(4'd3, 64'd43));
        tick(); expect_out("col_d44", 2'd3, mk(4'd3, 64'd44));
        tick(); expect_out("col_d45", 2'd3, mk(4'd3, 64'd45));
        tick(); check("col_idle", 71'(out_valid), 71'd0);

        // Reset mid-operation with FIFOs 1 and 2 non-empty
        out_ready = 1'b0;
        send(1, mk(4'd7, 64'd50));
        send(2, mk(4'd7, 64'd51));
        tick();
        send(1, mk(4'd7, 64'd52));
        send(2, mk(4'd7, 64'd53));
        tick();
        req_send = '0;
        expect_out("mid_before", 2'd1, mk(4'd7, 64'd50));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", 71'(out_valid),    71'd0);
        check("mid_async_flit",  out_flit,          71'd0);
        check("mid_async_ovf",   71'(req_overflow), 71'd0);
        check("mid_async_full",  71'(req_full),     71'd0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); check("mid_no_stale1", 71'(out_valid), 71'd0);
        tick(); check("mid_no_stale2", 71'(out_valid), 71'd0);
        send(2, mk(4'd9, 64'd60));
        tick();
        req_send = '0;
        check("mid_new_wait", 71'(out_valid), 71'd0);
        tick(); expect_out("mid_new", 2'd2, mk(4'd9, 64'd60));
        tick(); check("mid_final_idle", 71'(out_valid), 71'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Shares one router injection port between NUM_REQ compute nodes (adders, multipliers, ...), each of which emits 71-bit result flits with a one-cycle send pulse.
- Each requester gets a small FIFO so its pulses are never lost while the port is busy.
- A round-robin arbiter drains the FIFOs into a registered valid/ready output stage that feeds the router local input.
- Flits pass through unmodified.
- Flit format: [70] valid, [69] head/tail, [68:65] dest, [64] vc, [63:0] payload.

Parameters:
- NUM_REQ, 4, number of requesting compute nodes (2..8).
- FLIT_W, 71, flit width in bits.
- FIFO_DEPTH, 4, entries per requester FIFO; power of two, 2..16.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_flit  input  NUM_REQ*FLIT_W  requester i flit on bits [i*FLIT_W +: FLIT_W].
- req_send  input  NUM_REQ  one-cycle (or longer) push strobe per requester; each high cycle is one push.
- req_full  output  NUM_REQ  FIFO i full (status only; requesters are not required to honour it).
- req_overflow  output  NUM_REQ  sticky: a push to FIFO i was dropped.
- out_flit  output  FLIT_W  flit to router.
- out_valid  output  1  out_flit holds a flit.
- out_ready  input  1  router accepts out_flit this cycle.
- out_src  output  $clog2(NUM_REQ)  requester index of the current out_flit.

Behaviour:
- Reset (async assert, sync release):
  - All FIFOs empty.
  - req_full = 0, req_overflow = 0.
  - out_valid = 0, out_flit = 0, out_src = 0.
  - Round-robin pointer = 0.
- Push:
  - On each posedge where req_send[i] = 1, req_flit slice i is written to FIFO i.
  - The flit is stored verbatim; bit 70 is not checked.
- Full push:
  - If FIFO i is full and no pop from FIFO i occurs that edge, the flit is dropped and req_overflow[i] is set.
  - req_overflow[i] clears only on reset.
  - Push and pop to a full FIFO on the same edge: both happen, no drop, occupancy unchanged.
- Output register load condition:
  - load = (!out_valid || out_ready) && any FIFO non-empty.
  - Non-empty status is taken from the registered FIFO state before the current edge's pushes.
- Arbitration:
  - Round-robin.
  - The winner is the first non-empty FIFO at index ptr, ptr+1, ... modulo NUM_REQ.
  - On load: pop the winner's FIFO head into out_flit, set out_src = winner, out_valid = 1, ptr = winner+1 mod NUM_REQ.
  - ptr is unchanged when no load occurs.
- Drain without reload:
  - When out_valid && out_ready and no FIFO is non-empty, out_valid drops to 0 next edge.
  - out_flit and out_src hold their last values.
- Stall: while out_valid && !out_ready, out_flit, out_src and out_valid are held stable and no FIFO pops.
- Latency:
  - A flit pushed at edge k is popped no earlier than edge k+1.
  - With an idle port and empty FIFOs, out_valid rises after edge k+1.
- Throughput: one flit per cycle with out_ready held high.
- Ordering:
  - Per-requester FIFO order is preserved.
  - No ordering guarantee across requesters.
- Fairness: with all FIFOs continuously non-empty, grants rotate 0,1,..,NUM_REQ-1,0,...
- req_full[i] is combinational from FIFO i occupancy == FIFO_DEPTH.
- Reset mid-transfer: all buffered flits are discarded, out_valid drops immediately (asynchronously), no partial state remains.

Test Plan:
- Single push:
  - Stimulus: after reset, req_send[2] = 1 for one cycle, flit 71'h7_C0000000000000005.
  - Response: out_valid = 1 one cycle later with the same flit, out_src = 2.
  - With out_ready = 1, out_valid = 0 on the following cycle.
- Round-robin:
  - Stimulus: all 4 requesters push one flit in the same cycle (payloads 10, 11, 12, 13), out_ready = 1.
  - Response: outputs appear on 4 consecutive cycles with out_src = 0, 1, 2, 3, then out_valid = 0.
- Backpressure:
  - Stimulus: out_ready = 0 for 6 cycles while requester 1 pushes 3 flits.
  - Response: out_flit/out_src stable throughout.
  - After out_ready = 1, flits drain in push order on consecutive cycles.
- Overflow:
  - Stimulus: out_ready = 0, requester 0 pushes 6 flits.
  - Response:
    - The FIFO holds 4 flits.
    - out_flit holds the 1st flit, so the FIFO contains flits 2-5.
    - The 6th flit is dropped, req_full[0] = 1 and req_overflow[0] = 1.
    - req_overflow[0] stays 1 after draining.
- Full push/pop collision:
  - Stimulus: FIFO 3 full, out_ready = 1, requester 3 pushes on the same edge as its pop.
  - Response: no overflow, occupancy stays 4.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously with 2 FIFOs non-empty and out_valid = 1.
  - Response:
    - out_valid = 0 immediately, without a clock edge.
    - After release, no stale flit is ever output.
    - The first new push appears with out_src equal to its requester.
